// File: rtl/mips_prog_loader_if.sv
// Byte-stream and instruction-memory write bus of the MIPS32 program loader.
// slave = loader side, master = byte source / memory side.
interface mips_prog_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mips_prog_loader.sv
// Framed byte-stream loader filling the MIPS32 instruction memory.
// Define LOADER_HLT_PAD_EN to append an HLT word after programs shorter than Mem.
module mips_prog_loader #(
    parameter int         ADDR_W    = 10,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk1,
    input  logic              rst_n,
    mips_prog_loader_if.slave bus,
    output logic              core_hold,
    output logic              core_start,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef LOADER_HLT_PAD_EN
    localparam logic [31:0] HLT = 32'hfc000000;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_CHK,
        S_PAD,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [23:0]       word_q, word_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [7:0]        acc_q, acc_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   wl_q, wl_d;

    logic        take;
    logic        sync;
    logic [15:0] n_full;
    logic        n_bad;
    logic        last_word;

    assign bus.in_ready = (state_q != S_PAD);
    assign take         = bus.in_valid && bus.in_ready;
    assign sync         = take && (bus.in_data == SYNC_BYTE);
    assign n_full       = {cnt_q[15:8], bus.in_data};
    assign n_bad        = (n_full == 16'd0) || (32'(n_full) > DEPTH);
    assign last_word    = (32'(wl_q) + 32'd1) == 32'(cnt_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        bidx_d  = bidx_q;
        acc_d   = acc_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        start_d = 1'b0;
        busy_d  = busy_q;
        err_d   = err_q;
        wl_d    = wl_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (sync) begin
                    state_d = S_CNT_HI;
                    hold_d  = 1'b1;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    wl_d    = '0;
                    acc_d   = '0;
                    bidx_d  = '0;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_CNT_HI: begin
                if (take) begin
                    cnt_d[15:8] = bus.in_data;
                    state_d     = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (take) begin
                    cnt_d[7:0] = bus.in_data;
                    if (n_bad) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (take) begin
                    acc_d  = acc_q ^ bus.in_data;
                    word_d = {word_q[15:0], bus.in_data};
                    bidx_d = bidx_q + 2'd1;
                    // word index doubles as the write address
                    if (bidx_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = wl_q[ADDR_W-1:0];
                        wdata_d = {word_q, bus.in_data};
                        wl_d    = wl_q + (ADDR_W+1)'(1);
                        if (last_word) begin
                            state_d = S_CHK;
                        end
                    end
                end
            end
            S_CHK: begin
                if (take) begin
                    if (bus.in_data != acc_q) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end
`ifdef LOADER_HLT_PAD_EN
                    else if (32'(cnt_q) < DEPTH) begin
                        state_d = S_PAD;
                        we_d    = 1'b1;
                        addr_d  = cnt_q[ADDR_W-1:0];
                        wdata_d = HLT;
                    end
`endif
                    else begin
                        state_d = S_DONE;
                        start_d = 1'b1;
                        hold_d  = 1'b0;
                        busy_d  = 1'b0;
                    end
                end
            end
            S_PAD: begin
                state_d = S_DONE;
                start_d = 1'b1;
                hold_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            bidx_q  <= '0;
            acc_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b1;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            wl_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            bidx_q  <= bidx_d;
            acc_q   <= acc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            wl_q    <= wl_d;
        end
    end

    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign core_hold     = hold_q;
    assign core_start    = start_q;
    assign busy          = busy_q;
    assign err           = err_q;
    assign words_loaded  = wl_q;
endmodule

// File: tb/tb_mips_prog_loader.sv
// Scoreboard bench for mips_prog_loader: frames in, expected Mem writes
// and start pulses queued by a frame-level model, checked by a monitor.
module tb_mips_prog_loader;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef LOADER_HLT_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic            clk1 = 1'b0;
    logic            rst_n = 1'b1;
    logic            core_hold, core_start, busy, err;
    logic [ADDR_W:0] words_loaded;

    mips_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    mips_prog_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
        .clk1(clk1),
        .rst_n(rst_n),
        .bus(bus),
        .core_hold(core_hold),
        .core_start(core_start),
        .busy(busy),
        .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int unsigned       cyc;
    } wr_t;

    wr_t         exp_wr[$];
    int unsigned exp_start[$];
    int unsigned cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] pl [DEPTH];
    logic [31:0] prog [9];

    always @(posedge clk1) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every write and start pulse must match the head of its queue
    always @(negedge clk1) begin
        wr_t e;
        if (rst_n && bus.mem_we) begin
            if (exp_wr.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write: addr %0d data %h at cycle %0d, none expected",
                         bus.mem_addr, bus.mem_wdata, cyc);
            end else begin
                e = exp_wr.pop_front();
                check("wr_addr", 64'(bus.mem_addr), 64'(e.addr));
                check("wr_data", 64'(bus.mem_wdata), 64'(e.data));
                check("wr_cycle", 64'(cyc), 64'(e.cyc));
            end
            mem[bus.mem_addr] = bus.mem_wdata;
        end
        if (rst_n && core_start) begin
            if (exp_start.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_start: pulse at cycle %0d, none expected", cyc);
            end else begin
                check("start_cycle", 64'(cyc), 64'(exp_start.pop_front()));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps, output int unsigned acc_cyc);
        int waited;
        waited = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk1);
                #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        forever begin
            @(negedge clk1);
            if (bus.in_ready) break;
            waited++;
            if (waited > 16) begin
                compared++;
                mismatched++;
                $display("FAIL ready_timeout: in_ready low for %0d cycles, required 1", waited);
                break;
            end
        end
        @(posedge clk1);
        #1;
        acc_cyc      = cyc;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic send_header(input logic [15:0] n, input bit noise);
        int unsigned c;
        logic [7:0]  b;
        if (noise) begin
            send_byte(8'h00, 1'b0, c);
            send_byte(8'hFF, 1'b0, c);
            repeat ($urandom_range(1, 3)) begin
                do b = 8'($urandom); while (b == 8'hA5);
                send_byte(b, 1'b1, c);
            end
        end
        send_byte(8'hA5, 1'b0, c);
        send_byte(n[15:8], 1'b0, c);
        send_byte(n[7:0], 1'b0, c);
    endtask

    task automatic send_words(input int first, input int count, input bit gaps);
        int unsigned c;
        wr_t         e;
        for (int i = first; i < first + count; i++) begin
            for (int b = 3; b >= 0; b--) begin
                send_byte(pl[i][8*b +: 8], gaps, c);
            end
            e.addr = i[ADDR_W-1:0];
            e.data = pl[i];
            e.cyc  = c;
            exp_wr.push_back(e);
            ref_mem[i] = pl[i];
        end
    endtask

    task automatic check_mem(input string tag);
        int diffs;
        diffs = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i] !== ref_mem[i]) diffs++;
        end
        check({tag, "_mem_diffs"}, 64'(diffs), 64'd0);
    endtask

    task automatic check_pending(input string tag);
        check({tag, "_wr_pending"}, 64'(exp_wr.size()), 64'd0);
        check({tag, "_start_pending"}, 64'(exp_start.size()), 64'd0);
    endtask

    task automatic run_frame(input int n, input bit bad, input bit gaps, input bit noise,
                             input string tag);
        int unsigned     c;
        logic [7:0]      chk;
        logic [ADDR_W:0] nw;
        wr_t             e;
        send_header(16'(n), noise);
        check({tag, "_busy_hdr"}, 64'(busy), 64'd1);
        check({tag, "_hold_hdr"}, 64'(core_hold), 64'd1);
        check({tag, "_err_hdr"}, 64'(err), 64'd0);
        send_words(0, n, gaps);
        chk = 8'h00;
        for (int i = 0; i < n; i++) begin
            chk = chk ^ pl[i][31:24] ^ pl[i][23:16] ^ pl[i][15:8] ^ pl[i][7:0];
        end
        if (bad) chk = chk ^ 8'h01;
        send_byte(chk, gaps, c);
        if (!bad) begin
            if (PAD && n < DEPTH) begin
                e.addr = n[ADDR_W-1:0];
                e.data = 32'hfc000000;
                e.cyc  = c;
                exp_wr.push_back(e);
                ref_mem[n] = 32'hfc000000;
                exp_start.push_back(c + 1);
            end else begin
                exp_start.push_back(c);
            end
        end
        repeat (4) begin
            @(posedge clk1);
            #1;
        end
        nw = n[ADDR_W:0];
        check({tag, "_err"}, 64'(err), 64'(bad));
        check({tag, "_hold"}, 64'(core_hold), 64'(bad));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_words_loaded"}, 64'(words_loaded), 64'(nw));
        check_pending(tag);
        check_mem(tag);
    endtask

    task automatic bad_count(input logic [15:0] n, input string tag);
        int unsigned c;
        logic [7:0]  b;
        send_header(n, 1'b0);
        repeat (3) begin
            do b = 8'($urandom); while (b == 8'hA5);
            send_byte(b, 1'b0, c);
        end
        repeat (2) begin
            @(posedge clk1);
            #1;
        end
        check({tag, "_err"}, 64'(err), 64'd1);
        check({tag, "_hold"}, 64'(core_hold), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_words_loaded"}, 64'(words_loaded), 64'd0);
        check_pending(tag);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
        check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
        check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
        check({tag, "_core_hold"}, 64'(core_hold), 64'd1);
        check({tag, "_core_start"}, 64'(core_start), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_words_loaded"}, 64'(words_loaded), 64'd0);
    endtask

    task automatic load_prog(input int n);
        for (int i = 0; i < n; i++) pl[i] = prog[i];
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                 32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
            pl[i]      = 32'h0;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk1);
        #1;
        check_reset("por");
        rst_n = 1'b1;

        load_prog(9);
        run_frame(9, 1'b0, 1'b0, 1'b0, "prog");
        run_frame(9, 1'b1, 1'b0, 1'b0, "badchk");
        run_frame(9, 1'b0, 1'b0, 1'b0, "recover");
        run_frame(9, 1'b0, 1'b1, 1'b1, "noise_gaps");

        bad_count(16'd0, "n0");
        bad_count(16'd1025, "n1025");

        // reset after two words of a fresh 9-word frame
        for (int i = 0; i < 9; i++) pl[i] = $urandom;
        send_header(16'd9, 1'b0);
        send_words(0, 2, 1'b0);
        repeat (2) begin
            @(posedge clk1);
            #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check_reset("midrst");
        @(posedge clk1);
        #1 rst_n = 1'b1;
        check_pending("midrst");
        check_mem("midrst");
        load_prog(9);
        run_frame(9, 1'b0, 1'b0, 1'b0, "after_rst");

        load_prog(8);
        run_frame(8, 1'b0, 1'b0, 1'b0, "n8");

        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) pl[i] = $urandom;
            run_frame(n, ($urandom_range(0, 3) == 0), 1'b1, 1'b1, "rand");
        end

        for (int i = 0; i < DEPTH; i++) pl[i] = $urandom;
        run_frame(DEPTH, 1'b0, 1'b0, 1'b0, "full");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mips_prog_loader.md
Name: mips_prog_loader

Overview:
- Byte-stream program loader that sits directly upstream of the MIPS32 core's instruction memory (Mem).
- Receives a framed program over a valid/ready byte interface and assembles big-endian 32-bit instruction words.
- Writes each word into Mem starting at address 0, holding the core off while it does so.
- After the checksum verifies, releases the core with a one-cycle start pulse; the core then clears HALTED, PC and TAKEN_BRANCH.

Parameters:
- ADDR_W, 10, instruction memory address width; depth = 2**ADDR_W words.
- SYNC_BYTE, 8'hA5, frame header byte.

Ports:
- clk1  input  1  single loader clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  byte valid.
- in_data  input  8  byte value.
- in_ready  output  1  loader accepts a byte when in_valid && in_ready.
- mem_we  output  1  instruction memory write strobe.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  32  write data.
- core_hold  output  1  high = core must not fetch.
- core_start  output  1  one-cycle pulse: program loaded, core may reset PC and run.
- busy  output  1  frame in progress.
- err  output  1  sticky frame error.
- words_loaded  output  ADDR_W+1  words written by the last or current frame.

Behaviour:
- Clock and reset: one clock, clk1. Reset is asynchronous, active-low on rst_n.
- Reset values: state=IDLE, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, core_hold=1, core_start=0, busy=0, err=0, words_loaded=0.
- Frame format: SYNC_BYTE, then N_hi, N_lo (16-bit word count), then 4*N payload bytes with the MSB first per word, then a CHK byte. CHK = XOR of all payload bytes.
- States and transitions:
  - IDLE: bytes other than SYNC_BYTE are dropped. SYNC_BYTE → CNT_HI; busy=1, core_hold=1, words_loaded=0, checksum acc=0.
  - CNT_HI: latch N[15:8] → CNT_LO.
  - CNT_LO: latch N[7:0]. If N==0 or N>2**ADDR_W → ERR, else → DATA.
  - DATA: shift each byte into the word register and XOR it into acc. On the 4th byte, the next cycle has mem_we=1, mem_addr=word index, mem_wdata=assembled word, and words_loaded increments.
    - Write latency: exactly 1 cycle after the 4th byte is accepted.
    - in_ready stays 1; back-to-back bytes are legal.
    - After word N-1 is written → CHK.
  - CHK: if byte==acc → DONE, else → ERR.
  - DONE: one cycle. core_start=1, core_hold=0, busy=0 → IDLE.
  - ERR: err=1, busy=0, core_hold=1. Dropped bytes are discarded. SYNC_BYTE clears err and goes to CNT_HI.
- core_hold:
  - Stays 0 after a successful load until the next SYNC_BYTE is accepted, which reasserts it.
  - A failed frame leaves core_hold=1 even if an earlier frame succeeded; memory is partially overwritten.
- mem_addr wrap: none. The N check guarantees the address never exceeds 2**ADDR_W-1.
- Reset mid-frame: everything returns to reset values immediately; partially written words stay in memory.
- in_valid low in any state: hold state and assembly progress indefinitely; there is no timeout.

Optional Feature:
- Macro: LOADER_HLT_PAD_EN.
- When defined and N < 2**ADDR_W: after a verified CHK, one extra cycle writes 32'hfc000000 (HLT) at address N, then enters DONE. core_start is therefore delayed one cycle, and in_ready=0 during that cycle. words_loaded is unchanged.
- When not defined: no pad write; DONE follows CHK directly.

Test Plan:
- Load 9 words {2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000} with the correct CHK → Mem[0..8] match, words_loaded=9, core_start is one pulse, core_hold=0, err=0.
- Same frame with the CHK byte XOR 8'h01 → all 9 writes occur, err=1, core_hold=1, no core_start. A following good frame clears err and pulses core_start.
- Noise bytes 8'h00, 8'hFF before SYNC_BYTE, and random in_valid gaps inside the payload → bytes are ignored, the same 9 words are written, and each write is 1 cycle after its 4th byte.
- N=0, and N=1025 with ADDR_W=10 → ERR after N_lo with no mem_we. N=1024 → last write at addr 1023.
- Assert rst_n low after 2 words of a 9-word frame → outputs return to reset values asynchronously, Mem[0..1] keep their new values, and the next frame loads normally.
- LOADER_HLT_PAD_EN defined, N=8 (no HLT in payload) → extra write Mem[8]=fc000000, and core_start comes 1 cycle later than without the macro.
